// File: rtl/peri_capture_pkg.sv
// Shared constants and types for the peri_capture input-capture timer.
package peri_capture_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_COUNT   = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    localparam int unsigned CTRL_W        = 4;
    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_EDGE_LSB = 1;
    localparam int unsigned CTRL_EDGE_MSB = 2;
    localparam int unsigned CTRL_IRQ_EN   = 3;

    localparam int unsigned ST_W         = 3;
    localparam int unsigned ST_CAP_VALID = 0;
    localparam int unsigned ST_OVERRUN   = 1;
    localparam int unsigned ST_WRAP      = 2;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_sel_t;

endpackage

// File: rtl/peri_capture_if.sv
// Register bus between the CPU and the peri_capture peripheral.
interface peri_capture_if;

    logic        we_i;
    logic [1:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output we_i, output addr_i, output data_i, input  data_o);
    modport slave  (input  we_i, input  addr_i, input  data_i, output data_o);

endinterface

// File: rtl/peri_capture_sync.sv
// Multi-stage synchronizer for an asynchronous input followed by an edge detector.
module peri_capture_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    logic                   synced;

    assign synced = chain[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin_i};
            prev  <= synced;
        end
    end

    assign rise_o = synced & ~prev;
    assign fall_o = ~synced & prev;

endmodule

// File: rtl/peri_capture.sv
// Input-capture timer: free-running prescaled counter latched on a selected pin edge.
module peri_capture
    import peri_capture_pkg::*;
#(
    parameter int unsigned DIV         = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    peri_capture_if.slave bus,
    input  logic          cap_pin_i,
    output logic          irq_o
);

    localparam int unsigned    PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

    logic [CTRL_W-1:0] ctrl, ctrl_next;
    logic [ST_W-1:0]   status, status_next, clr;
    logic [31:0]       count, count_next, capture;
    logic [PW-1:0]     presc;
    logic              rise, fall, cap_evt, tick, wrap_set, irq_next;
    logic              wr_ctrl, wr_status, wr_count;
    edge_sel_t         edge_sel;

    peri_capture_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pin_i  (cap_pin_i),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign wr_ctrl   = bus.we_i && (bus.addr_i == ADDR_CTRL);
    assign wr_status = bus.we_i && (bus.addr_i == ADDR_STATUS);
    assign wr_count  = bus.we_i && (bus.addr_i == ADDR_COUNT);
    assign clr       = wr_status ? bus.data_i[ST_W-1:0] : '0;

    assign edge_sel = edge_sel_t'(ctrl[CTRL_EDGE_MSB:CTRL_EDGE_LSB]);
    assign tick     = ctrl[CTRL_EN] && (presc == PRE_LAST);
    // A COUNT write pre-empts the increment, so it cannot cause a wrap either.
    assign wrap_set = tick && !wr_count && (count == '1);

    always_comb begin
        cap_evt = 1'b0;
        case (edge_sel)
            EDGE_RISE: cap_evt = rise;
            EDGE_FALL: cap_evt = fall;
            EDGE_BOTH: cap_evt = rise | fall;
            default:   cap_evt = 1'b0;
        endcase
    end

    // Set events take priority over W1C; overrun sees the pre-write valid bit.
    always_comb begin
        ctrl_next = wr_ctrl ? bus.data_i[CTRL_W-1:0] : ctrl;
        count_next = count;
        if (wr_count) begin
            count_next = bus.data_i;
        end else if (tick) begin
            count_next = count + 32'd1;
        end
        status_next               = '0;
        status_next[ST_CAP_VALID] = cap_evt | (status[ST_CAP_VALID] & ~clr[ST_CAP_VALID]);
        status_next[ST_OVERRUN]   = (cap_evt & status[ST_CAP_VALID])
                                  | (status[ST_OVERRUN] & ~clr[ST_OVERRUN]);
        status_next[ST_WRAP]      = wrap_set | (status[ST_WRAP] & ~clr[ST_WRAP]);
        irq_next = ctrl_next[CTRL_IRQ_EN]
                 & (status_next[ST_CAP_VALID] | status_next[ST_WRAP]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl    <= '0;
            status  <= '0;
            count   <= '0;
            capture <= '0;
            presc   <= '0;
            irq_o   <= 1'b0;
        end else begin
            ctrl   <= ctrl_next;
            status <= status_next;
            count  <= count_next;
            irq_o  <= irq_next;
            if (cap_evt) begin
                capture <= count;
            end
            if (ctrl[CTRL_EN]) begin
                presc <= tick ? '0 : presc + PW'(1);
            end
        end
    end

    always_comb begin
        bus.data_o = '0;
        case (bus.addr_i)
            ADDR_CTRL:   bus.data_o = {{(32 - CTRL_W){1'b0}}, ctrl};
            ADDR_STATUS: bus.data_o = {{(32 - ST_W){1'b0}}, status};
            ADDR_COUNT:  bus.data_o = count;
            default:     bus.data_o = capture;
        endcase
    end

endmodule
